// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: stage scoreboard entry, forward encodings and
// the per-operand hazard check used for both rs and rt.
package cpu_defs;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   typedef struct packed {
      logic [4:0] a3;
      logic [1:0] tnew;
   } stage_t;

   typedef struct packed {
      logic [1:0] fwd;
      logic       haz;
   } opchk_t;

   function automatic logic [1:0] sat_dec(input logic [1:0] x);
      return (x != 2'd0) ? x - 2'd1 : 2'd0;
   endfunction

   // Newest producer wins (E > M > W); $0 never matches. A stall is needed
   // when that producer's result arrives later than the operand is consumed.
   function automatic opchk_t op_check(input logic [4:0] r, input logic [1:0] tuse,
                                       input stage_t e, input stage_t m, input stage_t w);
      opchk_t res;
      stage_t hit;
      res = '{fwd: FWD_RF, haz: 1'b0};
      hit = '0;
      if (r != 5'd0) begin
         if (e.a3 == r) begin
            res.fwd = FWD_E;
            hit     = e;
         end else if (m.a3 == r) begin
            res.fwd = FWD_M;
            hit     = m;
         end else if (w.a3 == r) begin
            res.fwd = FWD_W;
            hit     = w;
         end
      end
      res.haz = (res.fwd != FWD_RF) && (tuse != TUSE_NONE) && (hit.tnew > tuse);
      return res;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage request and hazard-control response bundle.
interface hazard_ctrl_if;
   logic       d_valid;
   logic [4:0] d_rs;
   logic [4:0] d_rt;
   logic [1:0] d_tuse_rs;
   logic [1:0] d_tuse_rt;
   logic [4:0] d_a3;
   logic [1:0] d_tnew;
   logic       d_md_start;
   logic       d_md_is_div;
   logic       d_md_use;
   logic       stall;
   logic       e_flush;
   logic [1:0] fwd_rs;
   logic [1:0] fwd_rt;
   logic       md_busy;

   modport master (
      output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
             d_md_start, d_md_is_div, d_md_use,
      input  stall, e_flush, fwd_rs, fwd_rt, md_busy
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
             d_md_start, d_md_is_div, d_md_use,
      output stall, e_flush, fwd_rs, fwd_rt, md_busy
   );
endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div busy counter: loads the unit latency on issue, then counts down.
module md_busy_cnt #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic is_div,
   output logic busy
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign busy = (cnt_q != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow E/M/W scoreboard, D-stage stall, forward selects
// and mult/div busy interlock.
module hazard_ctrl
   import cpu_defs::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  hif
);
   stage_t e_q, m_q, w_q;
   stage_t e_d, m_d, w_d;
   opchk_t rs_chk, rt_chk;
   logic   md_busy, md_stall, data_stall, stall, md_load;

   always_comb begin
      rs_chk = op_check(hif.d_rs, hif.d_tuse_rs, e_q, m_q, w_q);
      rt_chk = op_check(hif.d_rt, hif.d_tuse_rt, e_q, m_q, w_q);
   end

   assign data_stall = hif.d_valid && (rs_chk.haz || rt_chk.haz);
   assign md_stall   = hif.d_valid && (hif.d_md_start || hif.d_md_use) && md_busy;
   assign stall      = data_stall || md_stall;
   // Any stall, including a pure data hazard, keeps the mult/div from issuing.
   assign md_load    = hif.d_valid && hif.d_md_start && !stall;

   always_comb begin
      e_d = (stall || !hif.d_valid) ? '0 : stage_t'{a3: hif.d_a3, tnew: hif.d_tnew};
      m_d = stage_t'{a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
      w_d = stage_t'{a3: m_q.a3, tnew: sat_dec(m_q.tnew)};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   md_busy_cnt #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_md_cnt (
      .clk    (clk),
      .reset  (reset),
      .load   (md_load),
      .is_div (hif.d_md_is_div),
      .busy   (md_busy)
   );

   assign hif.stall   = stall;
   assign hif.e_flush = stall;
   assign hif.fwd_rs  = rs_chk.fwd;
   assign hif.fwd_rt  = rt_chk.fwd;
   assign hif.md_busy = md_busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-response queue.
module tb_hazard_ctrl;
   import cpu_defs::*;

   typedef struct {
      string      tag;
      logic       stall;
      logic [1:0] fwd_rs;
      logic [1:0] fwd_rt;
      logic       busy;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   hazard_ctrl_if hif();

   hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hif   (hif)
   );

   always #5 clk = ~clk;

   task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] trs, input logic [1:0] trt,
                      input logic [4:0] a3, input logic [1:0] tn,
                      input logic ms, input logic mdiv, input logic mu);
      hif.d_valid = v;     hif.d_rs = rs;        hif.d_rt = rt;
      hif.d_tuse_rs = trs; hif.d_tuse_rt = trt;  hif.d_a3 = a3;
      hif.d_tnew = tn;     hif.d_md_start = ms;  hif.d_md_is_div = mdiv;
      hif.d_md_use = mu;
   endtask

   task automatic nop();
      drv(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_out(input string tag, input logic st, input logic [1:0] frs,
                             input logic [1:0] frt, input logic bsy);
      exp_t e;
      e.tag = tag; e.stall = st; e.fwd_rs = frs; e.fwd_rt = frt; e.busy = bsy;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input string fld, input logic [1:0] obs,
                      input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
      end
   endtask

   task automatic check_now();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      cmp(e.tag, "stall",   {1'b0, hif.stall},   {1'b0, e.stall});
      cmp(e.tag, "e_flush", {1'b0, hif.e_flush}, {1'b0, e.stall});
      cmp(e.tag, "fwd_rs",  hif.fwd_rs,          e.fwd_rs);
      cmp(e.tag, "fwd_rt",  hif.fwd_rt,          e.fwd_rt);
      cmp(e.tag, "md_busy", {1'b0, hif.md_busy}, {1'b0, e.busy});
   endtask

   // Sample mid-cycle, then advance to just after the next rising edge.
   task automatic step();
      @(negedge clk);
      check_now();
      @(posedge clk);
      #1;
   endtask

   task automatic flush3();
      for (int i = 0; i < 3; i++) begin
         nop(); expect_out("flush", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      nop();
      expect_out("reset", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      reset = 1'b0;

      // Divide, then mflo stalls; async reset lands with md_cnt = 7.
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      expect_out("rst_div_issue", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd4, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         expect_out("rst_mflo_stall", 1'b1, FWD_RF, FWD_RF, 1'b1); step();
      end
      reset = 1'b1;
      #1;
      expect_out("rst_async", 1'b0, FWD_RF, FWD_RF, 1'b0); check_now();
      @(posedge clk); #1;
      reset = 1'b0;
      expect_out("rst_release", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      flush3();

      // Load-use with Tuse = 1.
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      expect_out("lu1_load", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd8, 5'd0, 2'd1, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("lu1_stall", 1'b1, FWD_E, FWD_RF, 1'b0); step();
      expect_out("lu1_fwd", 1'b0, FWD_M, FWD_RF, 1'b0); step();
      flush3();

      // Load-use with Tuse = 0 (branch).
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      expect_out("lu0_load", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd8, 5'd0, 2'd0, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("lu0_stall_e", 1'b1, FWD_E, FWD_RF, 1'b0); step();
      expect_out("lu0_stall_m", 1'b1, FWD_M, FWD_RF, 1'b0); step();
      expect_out("lu0_fwd_w", 1'b0, FWD_W, FWD_RF, 1'b0); step();
      flush3();

      // Newest producer wins: E {9,0} over M {9,1}.
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
      expect_out("nw_p1", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("nw_p2", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd0, 5'd9, TUSE_NONE, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("nw_use", 1'b0, FWD_RF, FWD_E, 1'b0); step();
      flush3();

      // $0 never matches; unused operand never stalls.
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      expect_out("z_p0", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd0, 5'd0, 2'd0, TUSE_NONE, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
      expect_out("z_r0", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd5, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      expect_out("z_unused", 1'b0, FWD_E, FWD_RF, 1'b0); step();
      flush3();

      // div at cycle 0, mflo stalls cycles 1..10, released at 11.
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      expect_out("md_div", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         expect_out($sformatf("md_mflo_c%0d", i), 1'b1, FWD_RF, FWD_RF, 1'b1); step();
      end
      expect_out("md_mflo_rel", 1'b0, FWD_RF, FWD_RF, 1'b0); step();

      // div then back-to-back mult: stalled until idle, then loads 5.
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
      expect_out("bb_div", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         expect_out($sformatf("bb_mult_c%0d", i), 1'b1, FWD_RF, FWD_RF, 1'b1); step();
      end
      expect_out("bb_mult_go", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      nop();
      for (int i = 1; i <= 5; i++) begin
         expect_out($sformatf("bb_mult_busy%0d", i), 1'b0, FWD_RF, FWD_RF, 1'b1); step();
      end
      expect_out("bb_mult_idle", 1'b0, FWD_RF, FWD_RF, 1'b0); step();

      // Data hazard blocks a mult issue on an idle unit.
      drv(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
      expect_out("dh_load", 1'b0, FWD_RF, FWD_RF, 1'b0); step();
      drv(1'b1, 5'd8, 5'd0, 2'd1, TUSE_NONE, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      expect_out("dh_mult_stall", 1'b1, FWD_E, FWD_RF, 1'b0); step();
      expect_out("dh_mult_go", 1'b0, FWD_M, FWD_RF, 1'b0); step();
      nop();
      expect_out("dh_mult_busy", 1'b0, FWD_RF, FWD_RF, 1'b1); step();

      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
